// File: rtl/ap_fifo_framer.sv
// ap_fifo stream framer: forwards header + payload unchanged with zero latency, then appends a
// checksum trailer word and counts completed packets.
module ap_fifo_framer #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 16,
  parameter int SUM_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] in_V_V_dout,
  input  logic              in_V_V_empty_n,
  output logic              in_V_V_read,
  output logic [DATA_W-1:0] out_V_V_din,
  input  logic              out_V_V_full_n,
  output logic              out_V_V_write,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    TRL = 2'd2
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [DATA_W-1:0]  acc_q;
  logic [CNT_W-1:0]   pktCount_q;
  logic               busy_q;

  logic               flowOk;
  logic [LEN_W-1:0]   lenField;
  logic [DATA_W-1:0]  accNext_d;

  // A word only moves through when both sides are ready, since nothing is buffered internally.
  assign flowOk   = in_V_V_empty_n & out_V_V_full_n & ~ap_rst;
  assign lenField = in_V_V_dout[LEN_W-1:0];

  always_comb begin
    accNext_d = acc_q + in_V_V_dout;
    if (SUM_MODE != 0) begin
      accNext_d = acc_q ^ in_V_V_dout;
    end
  end

  // Handshake and data path are combinational so forwarding is zero-latency; reset forces them low.
  always_comb begin
    in_V_V_read   = 1'b0;
    out_V_V_write = 1'b0;
    out_V_V_din   = '0;
    if (!ap_rst) begin
      case (state_q)
        HDR, PAY: begin
          in_V_V_read   = flowOk;
          out_V_V_write = flowOk;
          out_V_V_din   = in_V_V_dout;
        end
        TRL: begin
          out_V_V_write = out_V_V_full_n;
          out_V_V_din   = acc_q;
        end
        default: begin
          in_V_V_read   = 1'b0;
          out_V_V_write = 1'b0;
          out_V_V_din   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= HDR;
      remaining_q <= '0;
      acc_q       <= '0;
      pktCount_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        HDR: begin
          if (flowOk) begin
            remaining_q <= lenField;
            acc_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= (lenField == '0) ? TRL : PAY;
          end
        end
        PAY: begin
          if (flowOk) begin
            acc_q       <= accNext_d;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LEN_W'(1)) begin
              state_q <= TRL;
            end
          end
        end
        TRL: begin
          if (out_V_V_full_n) begin
            pktCount_q <= pktCount_q + 1'b1;
            busy_q     <= 1'b0;
            state_q    <= HDR;
          end
        end
        default: begin
          state_q <= HDR;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_count = pktCount_q;
  assign busy      = busy_q;

endmodule
